register_file: RTL and testbench
================================

Name: register_file

Overview:
- 32-entry general-purpose register file for the single-cycle MIPS datapath.
- Sits directly upstream of the ALU-source selection stage: `read_data2` drives the 32-bit ALU-source mux `data0` input; `read_data1` drives the ALU A input.
- Consumes the 5-bit RegDst mux output as `write_reg`, plus the write-back value.
- Two combinational read ports, one synchronous write port, `$zero` hardwired, optional write-to-read bypass.

Parameters:
- DATA_WIDTH, 32, register width in bits
- ADDR_WIDTH, 5, register index width; depth = 2**ADDR_WIDTH
- BYPASS, 1, 1 = same-cycle write data forwarded to matching read port; 0 = read returns stored value
- SP_INDEX, 29, index of the stack pointer register
- SP_RESET, 32'h0000_3FFC, reset value loaded into register SP_INDEX

Ports:
- clock  input  1  system clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- read_reg1  input  ADDR_WIDTH  read port 1 index (instr[25:21])
- read_reg2  input  ADDR_WIDTH  read port 2 index (instr[20:16])
- write_reg  input  ADDR_WIDTH  write index, from RegDst mux output
- write_data  input  DATA_WIDTH  write-back value
- reg_write  input  1  write enable from control
- read_data1  output  DATA_WIDTH  contents of read_reg1
- read_data2  output  DATA_WIDTH  contents of read_reg2, to ALU-source mux data0
- write_count  output  16  count of committed writes since reset (verification aid)

Behaviour:
- Clock and reset: one clock `clock`. Reset `reset` is synchronous, active-high, sampled on the rising edge.
- Reset:
  - on a rising edge with `reset`=1, every register clears to 0, except register SP_INDEX, which loads SP_RESET;
  - `write_count` clears to 0;
  - reset has priority over a simultaneous write, and that write is discarded.
- Reset values after the reset edge:
  - `read_data1`/`read_data2` = 0 for any index except SP_INDEX, which reads SP_RESET;
  - `write_count` = 0.
- Write:
  - on a rising edge with `reset`=0, `reg_write`=1 and `write_reg`≠0, the register at `write_reg` takes `write_data`;
  - `write_count` increments by 1 on the same edge.
- Register 0:
  - a write to index 0 is ignored: no storage change, `write_count` not incremented;
  - register 0 always reads 0.
- Read:
  - combinational, zero-cycle latency from `read_regN` to `read_dataN`;
  - a registered write becomes visible on the read port in the cycle after the write edge.
- Bypass (BYPASS=1):
  - if `reg_write`=1, `write_reg`≠0 and `write_reg`==`read_regN` in the same cycle, `read_dataN` = `write_data` combinationally;
  - both ports bypass independently;
  - bypass is suppressed while `reset`=1, and read data then shows stored contents.
- BYPASS=0: reads always return stored contents. The new value appears after the edge.
- `write_count` wraps from 16'hFFFF to 16'h0000 with no saturation.
- Same index on both ports: both ports return identical data.
- Unknown or X inputs to `reg_write` are not supported. The bench drives clean 0/1.
- No other state: no multi-cycle operations and no handshake. The block is ready every cycle.

Test Plan:
- Reset load: assert `reset` for 1 cycle with `reg_write`=1, `write_reg`=5, `write_data`=32'hDEAD_BEEF -> after the edge, `read_reg1`=5 reads 0, `read_reg2`=29 reads 32'h0000_3FFC, `write_count`=0.
- Basic write/read:
  - write 32'h1234_5678 to reg 8, then 32'hFFFF_FFFF to reg 31 on consecutive edges;
  - read 8 and 31 -> 32'h1234_5678 and 32'hFFFF_FFFF;
  - `write_count`=2.
- Register 0: `reg_write`=1, `write_reg`=0, `write_data`=32'hAAAA_AAAA for 3 edges -> reg 0 reads 0 throughout, `write_count` unchanged.
- Bypass (BYPASS=1):
  - drive `read_reg1`=`read_reg2`=`write_reg`=9, `write_data`=32'h0000_00FF, `reg_write`=1 before the edge -> both reads = 32'h0000_00FF in that same cycle;
  - with BYPASS=0 -> old value (0) until after the edge.
- Reset mid-operation:
  - write 7 to reg 3, then in the next cycle assert `reset` while writing 9 to reg 3;
  - -> reg 3 reads 0, reg 29 reads 32'h0000_3FFC, `write_count`=0.
- Counter wrap: 65536 writes to reg 1 with `write_data` = loop index -> `write_count`=0, reg 1 reads 32'h0000_FFFF.

Source files
------------

// File: rtl/register_file.sv
// register_file: 32-entry MIPS GPR file. It has two combinational read
// ports, one synchronous write port, and a hardwired $zero. Same-cycle
// write data can optionally be forwarded to the read ports. write_count
// tracks committed writes since reset.

// One read port: selects stored data, forces $zero, and optionally
// forwards the in-flight write.
module register_file_rdport #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter bit BYPASS     = 1'b1
) (
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [DATA_WIDTH-1:0] i_stored,
  input  logic                  i_wr_en,
  input  logic [ADDR_WIDTH-1:0] i_wr_addr,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  output logic [DATA_WIDTH-1:0] o_data
);

  logic w_hit;
  assign w_hit = BYPASS && i_wr_en && (i_wr_addr == i_addr);

  // Read mux priority: $zero first, then forwarded write, then storage.
  always_comb begin
    o_data = i_stored;
    if (i_addr == '0)
      o_data = '0;
    else if (w_hit)
      o_data = i_wr_data;
  end

endmodule

module register_file #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 5,
  parameter bit                    BYPASS     = 1'b1,
  parameter int                    SP_INDEX   = 29,
  parameter logic [DATA_WIDTH-1:0] SP_RESET   = 32'h0000_3FFC
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] read_reg1,
  input  logic [ADDR_WIDTH-1:0] read_reg2,
  input  logic [ADDR_WIDTH-1:0] write_reg,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic                  reg_write,
  output logic [DATA_WIDTH-1:0] read_data1,
  output logic [DATA_WIDTH-1:0] read_data2,
  output logic [15:0]           write_count
);

  localparam int DEPTH     = 2 ** ADDR_WIDTH;
  localparam int NUM_PORTS = 2;

  logic [DATA_WIDTH-1:0] r_regs [DEPTH];
  logic [15:0]           r_wr_cnt;

  // A write commits only outside reset and never to $zero. This same
  // qualifier gates forwarding, so reads during reset show storage.
  logic w_wr_en;
  assign w_wr_en = reg_write && !reset && (write_reg != '0);

  logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0] w_rd_addr;
  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] w_rd_raw;
  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] w_rd_data;

  assign w_rd_addr[0] = read_reg1;
  assign w_rd_addr[1] = read_reg2;

  // Storage: reset loads zeros plus the stack pointer; otherwise one write per edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++)
        r_regs[i] <= (i == SP_INDEX) ? SP_RESET : '0;
    end else if (w_wr_en) begin
      r_regs[write_reg] <= write_data;
    end
  end

  // Committed-write counter; wraps freely at 16 bits.
  always_ff @(posedge clock) begin
    if (reset)
      r_wr_cnt <= '0;
    else if (w_wr_en)
      r_wr_cnt <= r_wr_cnt + 16'd1;
  end

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_rd
    assign w_rd_raw[p] = r_regs[w_rd_addr[p]];

    register_file_rdport #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH),
      .BYPASS     (BYPASS)
    ) u_port (
      .i_addr    (w_rd_addr[p]),
      .i_stored  (w_rd_raw[p]),
      .i_wr_en   (w_wr_en),
      .i_wr_addr (write_reg),
      .i_wr_data (write_data),
      .o_data    (w_rd_data[p])
    );
  end

  assign read_data1  = w_rd_data[0];
  assign read_data2  = w_rd_data[1];
  assign write_count = r_wr_cnt;

endmodule

// File: tb/tb_register_file.sv
// Scoreboard bench for register_file. Two instances share the stimulus:
// one with forwarding enabled and one with it disabled. Stimulus pushes
// hand-computed expectations tagged with a cycle number. A monitor pops
// and compares them on the falling edge of that cycle.
module tb_register_file;

  logic        clock = 1'b0;
  logic        reset;
  logic [4:0]  read_reg1, read_reg2, write_reg;
  logic [31:0] write_data;
  logic        reg_write;
  logic [31:0] b_rd1, b_rd2, n_rd1, n_rd2;
  logic [15:0] b_cnt, n_cnt;

  register_file #(.BYPASS(1'b1)) dut_b (
    .clock(clock), .reset(reset), .read_reg1(read_reg1), .read_reg2(read_reg2),
    .write_reg(write_reg), .write_data(write_data), .reg_write(reg_write),
    .read_data1(b_rd1), .read_data2(b_rd2), .write_count(b_cnt));

  register_file #(.BYPASS(1'b0)) dut_n (
    .clock(clock), .reset(reset), .read_reg1(read_reg1), .read_reg2(read_reg2),
    .write_reg(write_reg), .write_data(write_data), .reg_write(reg_write),
    .read_data1(n_rd1), .read_data2(n_rd2), .write_count(n_cnt));

  always #5 clock = ~clock;

  typedef struct {
    int          cyc;
    int          sel;   // 0..2 bypass dut rd1/rd2/count, 3..5 non-bypass dut
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t q[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;
  bit   done   = 1'b0;

  function automatic logic [31:0] actual(int sel);
    case (sel)
      0: return b_rd1;
      1: return b_rd2;
      2: return {16'h0, b_cnt};
      3: return n_rd1;
      4: return n_rd2;
      default: return {16'h0, n_cnt};
    endcase
  endfunction

  task automatic push(int sel, logic [31:0] exp, string name);
    exp_t e;
    e.cyc = cyc; e.sel = sel; e.exp = exp; e.name = name;
    q.push_back(e);
  endtask

  // Same expectation on both instances (port 0/1/2).
  task automatic push2(int port, logic [31:0] exp, string name);
    push(port, exp, {name, "_byp"});
    push(port + 3, exp, {name, "_nobyp"});
  endtask

  task automatic step();
    @(posedge clock);
    cyc++;
    #1;
  endtask

  task automatic drive(logic rst, logic we, logic [4:0] wa, logic [31:0] wd,
                       logic [4:0] r1, logic [4:0] r2);
    reset = rst; reg_write = we; write_reg = wa; write_data = wd;
    read_reg1 = r1; read_reg2 = r2;
  endtask

  // Monitor: compare every expectation belonging to the current cycle.
  initial begin
    exp_t        e;
    logic [31:0] a;
    forever begin
      @(negedge clock);
      while (q.size() > 0 && q[0].cyc <= cyc) begin
        e = q.pop_front();
        checks++;
        if (e.cyc != cyc) begin
          errors++;
          $display("FAIL %s: not sampled in cycle %0d (now %0d)", e.name, e.cyc, cyc);
        end else begin
          a = actual(e.sel);
          if (a !== e.exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", e.name, a, e.exp, cyc);
          end
        end
      end
    end
  end

  // Watchdog bounds the whole run.
  initial begin
    #1_500_000;
    if (!done) begin
      $display("FAIL watchdog: run did not complete, %0d checks %0d errors", checks, errors);
      $fatal(1);
    end
  end

  initial begin
    // Reset with a colliding write that must be discarded.
    drive(1, 1, 5'd5, 32'hDEAD_BEEF, 5'd5, 5'd29);
    step();
    // Second reset cycle: storage now cleared, forwarding suppressed.
    push(0, 32'h0, "rst_nofwd_rd1");
    step();
    drive(0, 0, 5'd0, 32'h0, 5'd5, 5'd29);
    push2(0, 32'h0, "rst_r5");
    push2(1, 32'h0000_3FFC, "rst_sp");
    push2(2, 32'h0, "rst_cnt");
    step();

    // Basic write/read.
    drive(0, 1, 5'd8, 32'h1234_5678, 5'd8, 5'd31);
    step();
    drive(0, 1, 5'd31, 32'hFFFF_FFFF, 5'd8, 5'd31);
    push2(0, 32'h1234_5678, "wr_vis_next");
    push(1, 32'hFFFF_FFFF, "fwd_r31_byp");
    push(4, 32'h0, "fwd_r31_nobyp");
    step();
    drive(0, 0, 5'd0, 32'h0, 5'd8, 5'd31);
    push2(0, 32'h1234_5678, "rd_r8");
    push2(1, 32'hFFFF_FFFF, "rd_r31");
    push2(2, 32'd2, "cnt_2");
    step();

    // Writes to $zero are ignored and never forwarded.
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 5'd0, 32'hAAAA_AAAA, 5'd0, 5'd0);
      push2(0, 32'h0, "zero_rd1");
      push2(1, 32'h0, "zero_rd2");
      push2(2, 32'd2, "zero_cnt");
      step();
    end

    // Forwarding on both ports with the same index.
    drive(0, 1, 5'd9, 32'h0000_00FF, 5'd9, 5'd9);
    push(0, 32'h0000_00FF, "byp_rd1");
    push(1, 32'h0000_00FF, "byp_rd2");
    push(3, 32'h0, "nobyp_rd1_old");
    push(4, 32'h0, "nobyp_rd2_old");
    step();
    drive(0, 0, 5'd0, 32'h0, 5'd9, 5'd9);
    push2(0, 32'h0000_00FF, "r9_after_rd1");
    push2(1, 32'h0000_00FF, "r9_after_rd2");
    push2(2, 32'd3, "cnt_3");
    step();
    // Ports forward independently: only port 2 matches.
    drive(0, 1, 5'd10, 32'h0000_0055, 5'd9, 5'd10);
    push2(0, 32'h0000_00FF, "indep_rd1");
    push(1, 32'h0000_0055, "indep_rd2_byp");
    push(4, 32'h0, "indep_rd2_nobyp");
    step();
    drive(0, 0, 5'd0, 32'h0, 5'd10, 5'd0);
    push2(0, 32'h0000_0055, "r10");
    push2(2, 32'd4, "cnt_4");
    step();

    // Reset mid-operation with a colliding write.
    drive(0, 1, 5'd3, 32'd7, 5'd3, 5'd0);
    step();
    drive(1, 1, 5'd3, 32'd9, 5'd3, 5'd29);
    push2(0, 32'd7, "rst_mid_stored");
    step();
    drive(0, 0, 5'd0, 32'h0, 5'd3, 5'd29);
    push2(0, 32'h0, "rst_mid_r3");
    push2(1, 32'h0000_3FFC, "rst_mid_sp");
    push2(2, 32'h0, "rst_mid_cnt");
    step();
    drive(0, 0, 5'd0, 32'h0, 5'd9, 5'd31);
    push2(0, 32'h0, "rst_mid_r9");
    push2(1, 32'h0, "rst_mid_r31");
    step();

    // Counter wrap: 65536 writes to reg 1.
    for (int i = 0; i < 65536; i++) begin
      drive(0, 1, 5'd1, i, 5'd2, 5'd0);
      if (i == 65535) push2(2, 32'h0000_FFFF, "cnt_ffff");
      step();
    end
    drive(0, 0, 5'd0, 32'h0, 5'd1, 5'd1);
    push2(0, 32'h0000_FFFF, "wrap_r1_rd1");
    push2(1, 32'h0000_FFFF, "wrap_r1_rd2");
    push2(2, 32'h0, "wrap_cnt");
    step();
    step();

    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations never compared", q.size());
    end
    done = 1'b1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
